// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  localparam int NUM_COIN  = 3;
  localparam int COIN_IDX0 = 0;
  localparam int COIN_IDX1 = 1;
  localparam int COIN_IDX2 = 2;

endpackage

// File: rtl/stock_counter.sv
// Per-product stock counter: reload to STOCK_MAX, saturating decrement, empty flag.
module stock_counter #(
  parameter int STOCK_W   = 2,
  parameter int STOCK_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [STOCK_W-1:0] L_MAX = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W-1:0] L_ONE = STOCK_W'(1);

  logic [STOCK_W-1:0] r_count;

  // Stock register: load wins over decrement, never goes below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= L_MAX;
    end else if (i_load) begin
      r_count <= L_MAX;
    end else if (i_dec && (r_count != {STOCK_W{1'b0}})) begin
      r_count <= r_count - L_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == {STOCK_W{1'b0}});

endmodule

// File: rtl/multi_vend_ctrl.sv
// Vending controller: coin credit, product selection, one-cycle vend,
// unit-by-unit change return and per-product stock tracking.
module multi_vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_PROD   = 4,
  parameter int COIN_VAL0  = 1,
  parameter int COIN_VAL1  = 2,
  parameter int COIN_VAL2  = 5,
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 9,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 2,
  parameter int STOCK_MAX  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          coin,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  input  logic                restock,
  output logic [NUM_PROD-1:0] vend,
  output logic                change_pulse,
  output logic                reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [NUM_PROD-1:0] sold_out
);

  if ((MAX_CREDIT >= (1 << CREDIT_W)) || (PRICE > MAX_CREDIT) ||
      (STOCK_MAX >= (1 << STOCK_W))) begin : g_bad_param
    $error("multi_vend_ctrl: illegal parameter combination");
  end

  localparam logic [CREDIT_W:0]   L_COIN0 = (CREDIT_W+1)'(COIN_VAL0);
  localparam logic [CREDIT_W:0]   L_COIN1 = (CREDIT_W+1)'(COIN_VAL1);
  localparam logic [CREDIT_W:0]   L_COIN2 = (CREDIT_W+1)'(COIN_VAL2);
  localparam logic [CREDIT_W:0]   L_MAXC  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] L_ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] L_ZERO  = {CREDIT_W{1'b0}};

  vend_state_t         r_state;
  vend_state_t         w_next_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] r_change;
  logic [CREDIT_W-1:0] w_change_nxt;
  logic [NUM_PROD-1:0] r_vend;
  logic [NUM_PROD-1:0] w_vend_nxt;
  logic                r_reject;
  logic                w_reject_nxt;
  logic                w_load;
  logic [NUM_PROD-1:0] w_dec;
  logic [NUM_PROD-1:0] w_zero;

  logic                w_coin_onehot;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_coin_ok;
  logic                w_sel_ok;
  logic [CREDIT_W-1:0] w_vend_rem;

  function automatic logic sel_is_onehot(input logic [NUM_PROD-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < NUM_PROD; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 32'd1);
  endfunction

  // Coin decode: a coin is usable only if it is one-hot and fits under MAX_CREDIT.
  always_comb begin
    w_coin_onehot = (32'(coin[COIN_IDX0]) + 32'(coin[COIN_IDX1]) +
                     32'(coin[COIN_IDX2])) == 32'd1;
    if (coin[COIN_IDX0]) begin
      w_coin_val = L_COIN0;
    end else if (coin[COIN_IDX1]) begin
      w_coin_val = L_COIN1;
    end else if (coin[COIN_IDX2]) begin
      w_coin_val = L_COIN2;
    end else begin
      w_coin_val = {(CREDIT_W+1){1'b0}};
    end
    w_coin_sum = {1'b0, r_credit} + w_coin_val;
    w_coin_ok  = w_coin_onehot && (w_coin_sum <= L_MAXC);
    w_sel_ok   = sel_is_onehot(sel) && (r_credit >= L_PRICE) &&
                 ((sel & ~w_zero) != {NUM_PROD{1'b0}});
    w_vend_rem = (r_credit >= L_PRICE) ? (r_credit - L_PRICE) : L_ZERO;
  end

  // Next-state and datapath decode; any strobed coin not consumed is returned.
  always_comb begin
    w_next_state = r_state;
    w_credit_nxt = r_credit;
    w_change_nxt = r_change;
    w_vend_nxt   = {NUM_PROD{1'b0}};
    w_reject_nxt = (coin != 3'b000);
    w_load       = 1'b0;
    w_dec        = {NUM_PROD{1'b0}};
    case (r_state)
      ST_IDLE: begin
        w_load = restock;
        if (w_coin_ok) begin
          w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
          w_reject_nxt = 1'b0;
          w_next_state = ST_CREDIT;
        end else begin
          w_credit_nxt = L_ZERO;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          w_change_nxt = r_credit;
          w_next_state = (r_credit != L_ZERO) ? ST_CHANGE : ST_IDLE;
        end else if (w_sel_ok) begin
          w_vend_nxt   = sel;
          w_next_state = ST_VEND;
        end else if (w_coin_ok) begin
          w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
          w_reject_nxt = 1'b0;
        end else begin
          w_next_state = ST_CREDIT;
        end
      end
      ST_VEND: begin
        w_dec        = r_vend;
        w_credit_nxt = w_vend_rem;
        w_change_nxt = w_vend_rem;
        w_next_state = (w_vend_rem != L_ZERO) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (r_change <= L_ONE) begin
          w_change_nxt = L_ZERO;
          w_credit_nxt = L_ZERO;
          w_next_state = ST_IDLE;
        end else begin
          w_change_nxt = r_change - L_ONE;
          w_credit_nxt = (r_credit != L_ZERO) ? (r_credit - L_ONE) : L_ZERO;
        end
      end
      default: begin
        w_change_nxt = L_ZERO;
        w_credit_nxt = L_ZERO;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, credit, change and output pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_credit <= L_ZERO;
      r_change <= L_ZERO;
      r_vend   <= {NUM_PROD{1'b0}};
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_credit <= w_credit_nxt;
      r_change <= w_change_nxt;
      r_vend   <= w_vend_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  for (genvar g = 0; g < NUM_PROD; g++) begin : g_stock
    stock_counter #(
      .STOCK_W  (STOCK_W),
      .STOCK_MAX(STOCK_MAX)
    ) u_stock (
      .clk   (clk),
      .reset (reset),
      .i_load(w_load),
      .i_dec (w_dec[g]),
      .o_zero(w_zero[g])
    );
  end

  assign vend         = r_vend;
  assign change_pulse = (r_state == ST_CHANGE);
  assign reject       = r_reject;
  assign busy         = (r_state == ST_VEND) || (r_state == ST_CHANGE);
  assign credit       = r_credit;
  assign sold_out     = w_zero;

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Scoreboard bench for multi_vend_ctrl: stimulus pushes expected vend/reject/change
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_multi_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coin;
  logic [3:0] sel;
  logic       cancel;
  logic       restock;
  logic [3:0] vend;
  logic       change_pulse;
  logic       reject;
  logic       busy;
  logic [3:0] credit;
  logic [3:0] sold_out;

  localparam int EV_VEND = 0;
  localparam int EV_REJ  = 1;
  localparam int EV_CHG  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;

  evt_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  multi_vend_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .sel         (sel),
    .cancel      (cancel),
    .restock     (restock),
    .vend        (vend),
    .change_pulse(change_pulse),
    .reject      (reject),
    .busy        (busy),
    .credit      (credit),
    .sold_out    (sold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic push_evt(input int k, input logic [7:0] d);
    evt_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic take_evt(input int k, input logic [7:0] d);
    evt_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d data %0d want none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        bad++;
        $display("FAIL event_%0d: got kind %0d data %0d want kind %0d data %0d",
                 total, k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (vend != 4'b0000) take_evt(EV_VEND, 8'(vend));
    if (reject === 1'b1) take_evt(EV_REJ, 8'(credit));
    if (change_pulse === 1'b1) take_evt(EV_CHG, 8'(credit));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_coin(input logic [2:0] c);
    coin = c;
    tick();
    coin = 3'b000;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(name, 8'(busy), 8'd0);
  endtask

  task automatic buy(input logic [3:0] s);
    drop_coin(3'b100);
    push_evt(EV_VEND, 8'(s));
    sel = s;
    tick();
    sel = 4'b0000;
    wait_idle("buy_done");
  endtask

  task automatic refund(input int amt);
    for (int i = amt; i >= 1; i--) push_evt(EV_CHG, 8'(i));
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_idle("refund_done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    coin    = 3'b000;
    sel     = 4'b0000;
    cancel  = 1'b0;
    restock = 1'b0;
    tick();
    tick();
    chk("rst_credit", 8'(credit), 8'd0);
    chk("rst_vend", 8'(vend), 8'd0);
    chk("rst_change", 8'(change_pulse), 8'd0);
    chk("rst_reject", 8'(reject), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_sold_out", 8'(sold_out), 8'd0);
    reset = 1'b0;
    tick();

    // Coins 2,2,2 then product 1: one vend, one change unit.
    drop_coin(3'b010);
    drop_coin(3'b010);
    drop_coin(3'b010);
    chk("credit6", 8'(credit), 8'd6);
    push_evt(EV_VEND, 8'h02);
    push_evt(EV_CHG, 8'd1);
    sel = 4'b0010;
    tick();
    sel = 4'b0000;
    wait_idle("vend1_done");
    chk("vend1_credit", 8'(credit), 8'd0);

    // Multi-hot coin in IDLE is returned.
    push_evt(EV_REJ, 8'd0);
    drop_coin(3'b011);
    chk("multihot_credit", 8'(credit), 8'd0);

    // Overflowing coin: 5 + 5 > 9.
    drop_coin(3'b100);
    push_evt(EV_REJ, 8'd5);
    drop_coin(3'b100);
    chk("overflow_credit", 8'(credit), 8'd5);
    refund(5);
    chk("refund5_credit", 8'(credit), 8'd0);

    // Coins 1,2 then cancel.
    drop_coin(3'b001);
    drop_coin(3'b010);
    chk("credit3", 8'(credit), 8'd3);
    refund(3);
    chk("refund3_credit", 8'(credit), 8'd0);

    // Sell out product 0, sold-out sel ignored, restock only in IDLE.
    for (int i = 0; i < 3; i++) buy(4'b0001);
    chk("sold_out0", 8'(sold_out), 8'h01);
    drop_coin(3'b100);
    sel = 4'b0001;
    tick();
    sel = 4'b0000;
    chk("soldout_sel_credit", 8'(credit), 8'd5);
    chk("soldout_sel_busy", 8'(busy), 8'd0);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    chk("restock_in_credit", 8'(sold_out), 8'h01);
    refund(5);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    chk("restock_idle", 8'(sold_out), 8'h00);

    // Cancel beats sel in the same cycle.
    drop_coin(3'b100);
    drop_coin(3'b010);
    chk("credit7", 8'(credit), 8'd7);
    for (int i = 7; i >= 1; i--) push_evt(EV_CHG, 8'(i));
    cancel = 1'b1;
    sel    = 4'b0100;
    tick();
    cancel = 1'b0;
    sel    = 4'b0000;
    wait_idle("cancel_wins_done");
    chk("cancel_wins_credit", 8'(credit), 8'd0);
    chk("cancel_wins_stock", 8'(sold_out), 8'h00);

    // Reset in CHANGE with 2 units outstanding.
    for (int i = 0; i < 3; i++) buy(4'b1000);
    chk("sold_out3", 8'(sold_out), 8'h08);
    drop_coin(3'b010);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("pre_reset_busy", 8'(busy), 8'd1);
    reset = 1'b1;
    #1;
    chk("abort_change", 8'(change_pulse), 8'd0);
    chk("abort_credit", 8'(credit), 8'd0);
    chk("abort_stock", 8'(sold_out), 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_busy", 8'(busy), 8'd0);
    chk("post_reset_credit", 8'(credit), 8'd0);

    repeat (3) tick();
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_vend_ctrl.md
MULTI_VEND_CTRL -- requirements
Module: multi_vend_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROD, default 4: number of products.
REQ-002 SHALL have parameter COIN_VAL0 / COIN_VAL1 / COIN_VAL2, defaults 1 / 2 / 5: credit units per coin type.
REQ-003 SHALL have parameter PRICE, default 5: credit units per item, same for all products.
REQ-004 SHALL have parameter MAX_CREDIT, default 9: highest accepted credit.
REQ-005 SHALL have parameter CREDIT_W, default 4: credit width; elaboration SHALL fail if MAX_CREDIT >= 2**CREDIT_W or PRICE > MAX_CREDIT.
REQ-006 SHALL have parameter STOCK_W, default 2: stock counter width.
REQ-007 SHALL have parameter STOCK_MAX, default 3: stock after reset or restock.
REQ-008 SHALL have one clock and an asynchronous, active-high reset.
REQ-009 SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- coin  in  3  coin strobe, one bit per coin type; valid only when exactly one bit is set
- sel  in  NUM_PROD  product request; valid only when one-hot
- cancel  in  1  refund request
- restock  in  1  refill all stock to STOCK_MAX
- vend  out  NUM_PROD  one-cycle dispense pulse
- change_pulse  out  1  one credit unit returned per asserted cycle
- reject  out  1  one-cycle coin-returned pulse
- busy  out  1  high in VEND and CHANGE
- credit  out  CREDIT_W  current credit
- sold_out  out  NUM_PROD  high when stock[i] == 0

Function
REQ-010 SHALL implement four states: IDLE, CREDIT, VEND, CHANGE; all outputs SHALL be registered or decoded from registered state and counters only.
REQ-011 IDLE: credit == 0; a valid coin SHALL add its value and move to CREDIT on the next edge.
REQ-012 CREDIT, per-cycle priority cancel > sel > coin:
- cancel: load the change counter with credit; go to CHANGE.
- valid sel[i] with credit >= PRICE and stock[i] > 0: go to VEND.
- sel that is invalid, underfunded or sold out: ignore; credit is held.
- valid coin: add its value.
REQ-013 A coin SHALL be rejected (reject = 1 for one cycle after the strobe, credit unchanged) when it is multi-hot, when credit + value > MAX_CREDIT, or when the block is in VEND or CHANGE.
REQ-014 VEND SHALL last exactly one cycle:
- vend[i] = 1.
- stock[i] decrements by 1.
- the change counter loads credit - PRICE.
- next state is CHANGE if that value is > 0, else IDLE.
REQ-015 CHANGE:
- change_pulse = 1 every cycle.
- the counter and credit decrement by 1 per cycle.
- return to IDLE after the last unit, with credit = 0.
- sel and cancel are ignored.
REQ-016 restock SHALL take effect only in IDLE and set all stock counters to STOCK_MAX; in any other state it is ignored.
REQ-017 Credit arithmetic SHALL never wrap; stock SHALL never decrement below 0.

Reset
REQ-018 While reset is high:
- state = IDLE, credit = 0, change counter = 0.
- vend, change_pulse, reject = 0.
- every stock = STOCK_MAX, so sold_out = 0.
REQ-019 Reset mid-operation SHALL abort immediately: no further vend or change_pulse, and pending change is lost.

Structure
REQ-020 A shared package vend_pkg SHALL hold the state type and the coin-index constants.
REQ-021 A per-product sub-module stock_counter SHALL provide load, decrement and zero-flag behaviour, instantiated NUM_PROD times.

Verification (default parameters)
REQ-022 Coins 2, 2, 2 then sel = 0010 -> credit 6; vend[1] one cycle; exactly 1 change_pulse; then IDLE with credit 0 and stock[1] = 2.
REQ-023 Coin 5, then coin 5 -> second coin gives reject = 1 for one cycle; credit stays 5.
REQ-024 Coins 1, 2, then cancel -> 3 consecutive change_pulse cycles, no vend, credit ends at 0.
REQ-025 Three purchases of product 0 -> sold_out[0] = 1; a fourth sel = 0001 with credit 5 is ignored and credit is held; cancel, then restock in IDLE -> sold_out[0] = 0.
REQ-026 Credit 7 with cancel and sel = 0100 in the same cycle -> cancel wins: 7 change pulses, no vend.
REQ-027 Reset asserted in CHANGE with 2 units outstanding -> change_pulse drops at once; credit 0; all stocks 3.
